gelato_warp_scheduler: RTL and testbench

Per-SM warp scheduler: each cycle selects one eligible warp from up to NUM_WARPS instruction-buffer heads and issues its decoded instruction to the operand collector. It sits between the per-warp instruction buffers and scoreboard on the input side and the operand collector on the output side, and holds at most one instruction in flight in its output register. Selection is round-robin; an optional greedy mode keeps issuing from the last-issued warp while that warp stays eligible.

---
 rtl/gelato_types.sv | 25 ++
 rtl/gelato_rr_arbiter.sv | 42 ++++
 rtl/gelato_warp_scheduler.sv | 121 ++++++++++++
 tb/tb_gelato_warp_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_types.sv
// Shared GPU SM types.
//   NUM_WARPS       : default warps per SM
//   inst_t          : decoded instruction carried from instruction buffer to operand collector
//   warp_id_t       : warp index sized from NUM_WARPS
//   warpskd_state_e : warp scheduler output-register state
package gelato_types;

  localparam int unsigned NUM_WARPS = 8;
  localparam int unsigned WARP_ID_W = $clog2(NUM_WARPS);

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] rd;
    logic [7:0] rs1;
    logic [7:0] rs2;
  } inst_t;

  typedef logic [WARP_ID_W-1:0] warp_id_t;

  typedef enum logic {
    EMPTY,
    HOLD
  } warpskd_state_e;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Grants the first requester at or after ptr, wrapping from N-1 back to 0.
// N must be a power of two so the index arithmetic wraps for free.
// Ports:
//   req       : request vector
//   ptr       : highest-priority index
//   gnt       : one-hot grant (zero when no request)
//   gnt_id    : binary index of the grant
//   gnt_valid : any request present
module gelato_rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid
);

  localparam int unsigned IdW = $clog2(N);

  logic [IdW-1:0] idx;

  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    // Scan from farthest to nearest offset so the nearest requester wins.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = ptr + IdW'(i);
      if (req[idx]) begin
        gnt_id    = idx;
        gnt_valid = 1'b1;
      end
    end
    gnt = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (gnt_valid && (gnt_id == IdW'(j))) gnt[j] = 1'b1;
    end
  end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Per-SM warp scheduler. Each cycle picks one eligible warp (active, head valid,
// scoreboard ready), pops its instruction-buffer head and loads the instruction into a
// single-entry output register that hands off to the operand collector.
// Optional macro GELATO_WARPSKD_GREEDY_EN: keep issuing from the last-issued warp while it
// stays eligible, otherwise fall back to round-robin.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   warp_active/valid/ready : per-warp eligibility terms
//   warp_inst         : per-warp head instruction
//   warp_pop          : one-hot pop of the granted head (combinational)
//   issue_valid/inst/wid, issue_ready : output handshake to the operand collector
//   stall_cnt         : saturating count of cycles held with issue_ready low
module gelato_warp_scheduler
  import gelato_types::*;
#(
  parameter int unsigned NUM_WARPS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WARPS-1:0]         warp_active,
  input  logic [NUM_WARPS-1:0]         warp_valid,
  input  logic [NUM_WARPS-1:0]         warp_ready,
  input  inst_t [NUM_WARPS-1:0]        warp_inst,
  output logic [NUM_WARPS-1:0]         warp_pop,
  output logic                         issue_valid,
  output inst_t                        issue_inst,
  output logic [$clog2(NUM_WARPS)-1:0] issue_wid,
  input  logic                         issue_ready,
  output logic [31:0]                  stall_cnt
);

  localparam int unsigned WARP_ID_W = $clog2(NUM_WARPS);

  warpskd_state_e       state_q;
  inst_t                inst_q;
  logic [WARP_ID_W-1:0] wid_q;
  logic [WARP_ID_W-1:0] rr_ptr_q;
  logic [31:0]          stall_cnt_q;

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] arb_gnt;
  logic [WARP_ID_W-1:0] arb_id;
  logic                 arb_valid;
  logic [NUM_WARPS-1:0] grant_oh;
  logic [WARP_ID_W-1:0] grant_id;
  logic                 grant_valid;
  logic                 load;

  assign eligible    = warp_active & warp_valid & warp_ready;
  assign issue_valid = (state_q == HOLD);
  // Output register is free when empty or being drained this cycle.
  assign load        = !issue_valid || issue_ready;

  gelato_rr_arbiter #(
    .N (NUM_WARPS)
  ) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

`ifdef GELATO_WARPSKD_GREEDY_EN
  logic [WARP_ID_W-1:0] last_wid_q;

  always_comb begin
    grant_valid = arb_valid;
    grant_id    = arb_id;
    grant_oh    = arb_gnt;
    if (eligible[last_wid_q]) begin
      grant_valid          = 1'b1;
      grant_id             = last_wid_q;
      grant_oh             = '0;
      grant_oh[last_wid_q] = 1'b1;
    end
  end
`else
  assign grant_valid = arb_valid;
  assign grant_id    = arb_id;
  assign grant_oh    = arb_gnt;
`endif

  // Gated by rst_n so nothing is popped while the register is being cleared.
  assign warp_pop = (rst_n && load && grant_valid) ? grant_oh : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      inst_q      <= '0;
      wid_q       <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
`ifdef GELATO_WARPSKD_GREEDY_EN
      last_wid_q  <= '0;
`endif
    end else begin
      if (issue_valid && !issue_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (load) begin
        if (grant_valid) begin
          state_q    <= HOLD;
          inst_q     <= warp_inst[grant_id];
          wid_q      <= grant_id;
          rr_ptr_q   <= grant_id + WARP_ID_W'(1);
`ifdef GELATO_WARPSKD_GREEDY_EN
          last_wid_q <= grant_id;
`endif
        end else begin
          state_q <= EMPTY;
        end
      end
    end
  end

  assign issue_inst = inst_q;
  assign issue_wid  = wid_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Self-checking bench for gelato_warp_scheduler (NUM_WARPS = 8): directed table,
// hand-written multi-cycle sequences and a randomized run against a reference model.
module tb_gelato_warp_scheduler;
  import gelato_types::*;

  localparam int NW = 8;

  logic            clk;
  logic            rst_n;
  logic [NW-1:0]   warp_active;
  logic [NW-1:0]   warp_valid;
  logic [NW-1:0]   warp_ready;
  inst_t [NW-1:0]  warp_inst;
  logic [NW-1:0]   warp_pop;
  logic            issue_valid;
  inst_t           issue_inst;
  logic [2:0]      issue_wid;
  logic            issue_ready;
  logic [31:0]     stall_cnt;

  gelato_warp_scheduler #(
    .NUM_WARPS (NW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .warp_active (warp_active),
    .warp_valid  (warp_valid),
    .warp_ready  (warp_ready),
    .warp_inst   (warp_inst),
    .warp_pop    (warp_pop),
    .issue_valid (issue_valid),
    .issue_inst  (issue_inst),
    .issue_wid   (issue_wid),
    .issue_ready (issue_ready),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef GELATO_WARPSKD_GREEDY_EN
  localparam bit Greedy = 1'b1;
`else
  localparam bit Greedy = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: output slot, round-robin pointer, last grant, stall count.
  bit          m_valid;
  int          m_wid;
  inst_t       m_inst;
  int          m_ptr;
  int          m_last;
  longint      m_stall;

  function automatic void model_reset();
    m_valid = 1'b0;
    m_wid   = 0;
    m_inst  = '0;
    m_ptr   = 0;
    m_last  = 0;
    m_stall = 0;
  endfunction

  task automatic set_in(logic r, logic [7:0] act, logic [7:0] val, logic [7:0] rdy, logic ir);
    rst_n       = r;
    warp_active = act;
    warp_valid  = val;
    warp_ready  = rdy;
    issue_ready = ir;
    for (int w = 0; w < NW; w++) warp_inst[w] = $urandom;
  endtask

  // Compare all outputs with the model, then advance one clock and update the model.
  task automatic step();
    logic [7:0] elig;
    logic [7:0] exp_pop;
    int         g;
    #1;
    elig = warp_active & warp_valid & warp_ready;
    g = -1;
    if (rst_n && (!m_valid || issue_ready)) begin
      if (Greedy && elig[m_last]) g = m_last;
      for (int k = 0; k < NW; k++) begin
        if (g < 0 && elig[(m_ptr + k) % NW]) g = (m_ptr + k) % NW;
      end
    end
    exp_pop = (g >= 0) ? 8'(1 << g) : 8'h00;
    chk("model_pop", 64'(warp_pop), 64'(exp_pop));
    chk("model_issue_valid", 64'(issue_valid), 64'(m_valid));
    chk("model_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (m_valid) begin
      chk("model_issue_wid", 64'(issue_wid), 64'(m_wid));
      chk("model_issue_inst", 64'(issue_inst), 64'(m_inst));
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_valid && !issue_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (!m_valid || issue_ready) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_wid   = g;
          m_inst  = warp_inst[g];
          m_ptr   = (g + 1) % NW;
          m_last  = g;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] elig;
    logic       ir;
    logic [7:0] exp_pop;
    logic       exp_iv;
    logic [2:0] exp_wid;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Reset for three cycles with everything eligible, then a 10-cycle free run.
    for (int r = 0; r < 3; r++) vecs[r] = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0};
    for (int k = 0; k < 10; k++) begin
      vecs[3 + k].rst_n   = 1'b1;
      vecs[3 + k].elig    = 8'hFF;
      vecs[3 + k].ir      = 1'b1;
      vecs[3 + k].exp_pop = Greedy ? 8'h01 : 8'(1 << (k % NW));
      vecs[3 + k].exp_iv  = (k > 0);
      vecs[3 + k].exp_wid = (k == 0 || Greedy) ? 3'd0 : 3'((k - 1) % NW);
    end

    model_reset();
    set_in(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].rst_n, vecs[i].elig, vecs[i].elig, vecs[i].elig, vecs[i].ir);
      #1;
      chk($sformatf("vec%0d_pop", i), 64'(warp_pop), 64'(vecs[i].exp_pop));
      chk($sformatf("vec%0d_valid", i), 64'(issue_valid), 64'(vecs[i].exp_iv));
      if (vecs[i].exp_iv) chk($sformatf("vec%0d_wid", i), 64'(issue_wid), 64'(vecs[i].exp_wid));
      step();
    end

    // Backpressure while holding warp 3.
    set_in(1'b1, 8'h08, 8'h08, 8'h08, 1'b1);
    #1;
    chk("bp_load_pop", 64'(warp_pop), 64'h08);
    step();
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      #1;
      chk("bp_hold_pop", 64'(warp_pop), 64'h00);
      chk("bp_hold_wid", 64'(issue_wid), 64'd3);
      chk("bp_hold_valid", 64'(issue_valid), 64'd1);
      step();
    end
    set_in(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    #1;
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("bp_release_pop", 64'(warp_pop), Greedy ? 64'h08 : 64'h10);
    step();

    // Wrap with sparse requests: rr_ptr = 6, eligible = {0, 2}.
    set_in(1'b1, 8'h20, 8'h20, 8'h20, 1'b1);
    #1;
    chk("wrap_setup_pop", 64'(warp_pop), 64'h20);
    step();
    set_in(1'b1, 8'h05, 8'h05, 8'h05, 1'b1);
    #1;
    chk("wrap_first_pop", 64'(warp_pop), 64'h01);
    step();
    set_in(1'b1, 8'h05, 8'h05, 8'h05, 1'b1);
    #1;
    chk("wrap_second_pop", 64'(warp_pop), Greedy ? 64'h01 : 64'h04);
    step();

    // Warps 1 and 2 eligible after warp 1 was last granted.
    set_in(1'b1, 8'h02, 8'h02, 8'h02, 1'b1);
    #1;
    chk("pair_setup_pop", 64'(warp_pop), 64'h02);
    step();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 8'h06, 8'h06, 8'h06, 1'b1);
      #1;
      chk($sformatf("pair_pop%0d", c), 64'(warp_pop),
          Greedy ? 64'h02 : ((c % 2 == 0) ? 64'h04 : 64'h02));
      step();
    end
    set_in(1'b1, 8'h06, 8'h06, 8'h04, 1'b1);
    #1;
    chk("pair_unready_pop", 64'(warp_pop), 64'h04);
    step();

    // Reset while holding an instruction.
    set_in(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    #1;
    chk("rst_hold_pop", 64'(warp_pop), 64'h00);
    step();
    set_in(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    #1;
    chk("rst_cycle_pop", 64'(warp_pop), 64'h00);
    chk("rst_cycle_valid", 64'(issue_valid), 64'd1);
    step();
    set_in(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    #1;
    chk("rst_after_valid", 64'(issue_valid), 64'd0);
    chk("rst_after_stall", 64'(stall_cnt), 64'd0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [7:0] a, v, r;
      a = 8'($urandom) | 8'($urandom);
      v = 8'($urandom) | 8'($urandom);
      r = 8'($urandom) & 8'($urandom | $urandom);
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      set_in(($urandom_range(0, 49) != 0), a, v, r, ($urandom_range(0, 9) < 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
